dmem_bus_responder: RTL and testbench

- Target-side responder for the Data Memory window, DEV_DMEM at 0x2000_0000.
- Accepts one core load/store request per valid/ready handshake and services it from an internal byte-enabled RAM.
- Returns read data, or an error, on a separate valid/ready response channel.
- Sits behind the core's address decoder. It re-checks the decode itself so that mis-routed requests produce an error response.

---
 rtl/memory_pkg.sv | 47 ++++
 rtl/dmem_byte_ram.sv | 43 ++++
 rtl/dmem_bus_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared memory-map definitions for the core's target devices.
//   DMEM_BASE / DMEM_MASK   : Data Memory window (DEV_DMEM at 0x2000_0000)
//   decode_address()        : maps a byte address to the device it falls in
//   dmem_rsp_state_t        : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_MAX_WAIT_STATES    : largest supported response wait-state count
//   dmem_be_t               : 4-lane byte-enable type
//   be_to_mask()            : expands byte enables into a 32-bit lane mask
// -----------------------------------------------------------------------------
package memory_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h2000_0000;
  localparam logic [31:0] DMEM_MASK = 32'hF000_0000;

  localparam int DMEM_MAX_WAIT_STATES = 7;

  typedef logic [3:0] dmem_be_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_rsp_state_t;

  typedef enum logic [1:0] {
    DEV_NONE = 2'd0,
    DEV_DMEM = 2'd1
  } mem_dev_t;

  function automatic mem_dev_t decode_address(input logic [31:0] addr);
    mem_dev_t dev;
    dev = DEV_NONE;
    if ((addr & DMEM_MASK) == DMEM_BASE) dev = DEV_DMEM;
    return dev;
  endfunction

  function automatic logic [31:0] be_to_mask(input dmem_be_t be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mask[8*i +: 8] = 8'hFF;
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// -----------------------------------------------------------------------------
// dmem_byte_ram
// Synchronous single-port RAM, DEPTH 32-bit words, per-byte-lane write enable,
// registered read. Contents are never cleared.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access enable for this edge
//   we     in   1 = write the enabled lanes, 0 = read into rdata
//   be     in   byte-lane write enables
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data; holds its value on edges without a read
// -----------------------------------------------------------------------------
module dmem_byte_ram
  import memory_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  dmem_be_t      be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// -----------------------------------------------------------------------------
// dmem_bus_responder
// Target-side responder for the Data Memory window. Accepts one load/store per
// request handshake, services it from dmem_byte_ram and returns data or an
// error on the response channel. Only one transaction is outstanding.
//
// Handshake: a request transfers on an edge where req_valid_i && req_ready_o;
// a response transfers on an edge where rsp_valid_o && rsp_ready_i. Both
// ready and valid outputs come from registers only; once rsp_valid_o rises,
// rsp_rdata_o and rsp_err_o hold until the response transfers.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_addr_i, req_we_i     byte address, 1 = store
//   req_be_i, req_wdata_i    byte enables, store data
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   load data (0 for stores/errors), access error
// Optional (macro DMEM_ACCESS_STATS_EN):
//   stat_rd_o, stat_wr_o, stat_err_o  saturating 16-bit access counters
// -----------------------------------------------------------------------------
module dmem_bus_responder
  import memory_pkg::*;
#(
  parameter int          SIZE_BYTES  = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  dmem_be_t    req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [15:0] stat_rd_o,
  output logic [15:0] stat_wr_o,
  output logic [15:0] stat_err_o
`endif
);

  localparam int          WORDS     = SIZE_BYTES / 4;
  localparam int          OFF_W     = $clog2(SIZE_BYTES);
  localparam int          CNT_W     = $clog2(DMEM_MAX_WAIT_STATES + 1);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  dmem_rsp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             err_q;
  logic             load_q;
  dmem_be_t         be_q;

  logic             accept;
  logic [31:0]      offset;
  logic             in_window, in_range, aligned, be_any, req_err;
  logic [31:0]      ram_rdata;

  // Decode re-check: a mis-routed or malformed request never touches the RAM.
  assign accept    = req_valid_i && ready_q;
  assign offset    = req_addr_i - BASE_ADDR;
  assign in_window = (decode_address(req_addr_i) == DEV_DMEM) &&
                     ((req_addr_i & DMEM_MASK) == BASE_ADDR);
  assign in_range  = offset < 32'(SIZE_BYTES);
  assign aligned   = (req_addr_i[1:0] == 2'b00);
  assign be_any    = (req_be_i != 4'b0000);
  assign req_err   = !(in_window && in_range && aligned && be_any);

  // The RAM is read at the acceptance edge and its output register is only
  // re-loaded by the next accepted load, so the data stays stable through
  // WAIT and RESP regardless of backpressure.
  dmem_byte_ram #(
    .DEPTH (WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (accept && !req_err),
    .we    (req_we_i),
    .be    (req_be_i),
    .addr  (offset[OFF_W-1:2]),
    .wdata (req_wdata_i),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err || WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready_q tracks "next state is IDLE" so it is low while reset is applied
  // and rises one edge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (accept) begin
        err_q  <= req_err;
        load_q <= !req_we_i;
        be_q   <= req_be_i;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && load_q && !err_q) ?
                       (ram_rdata & be_to_mask(be_q)) : 32'h0;

`ifdef DMEM_ACCESS_STATS_EN
  logic        rsp_hs;
  logic [15:0] stat_rd_q, stat_wr_q, stat_err_q;

  assign rsp_hs = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else if (rsp_hs) begin
      if (err_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
      end else if (load_q) begin
        if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      end else begin
        if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
      end
    end
  end

  assign stat_rd_o  = stat_rd_q;
  assign stat_wr_o  = stat_wr_q;
  assign stat_err_o = stat_err_q;
`endif

endmodule

// File: tb/tb_dmem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_responder
// Self-checking bench for dmem_bus_responder: a table of load/store vectors,
// hand-written backpressure and mid-transaction reset sequences, a randomized
// load/store phase against a word model, and (with DMEM_ACCESS_STATS_EN) the
// access counters. Expected responses are queued when a request is driven and
// popped when the response appears.
// -----------------------------------------------------------------------------
module tb_dmem_bus_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] stat_rd_o, stat_wr_o, stat_err_o;
`endif

  dmem_bus_responder #(
    .SIZE_BYTES  (4096),
    .BASE_ADDR   (32'h2000_0000),
    .WAIT_STATES (WS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .stat_rd_o   (stat_rd_o),
    .stat_wr_o   (stat_wr_o),
    .stat_err_o  (stat_err_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {err, rdata}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timeout", name);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_be_i    = be;
    req_wdata_i = wdata;
  endtask

  task automatic idle_req();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h0;
    req_be_i    = 4'h0;
    req_wdata_i = 32'h0;
  endtask

  // Full transaction with rsp_ready_i held high; checks latency and payload.
  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    int guard;
    int lat;
    logic [32:0] e;
    exp_q.push_back({exp_err, exp_rd});
    rsp_ready_i = 1'b1;
    drive_req(we, addr, be, wdata);
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      step();
      guard++;
    end
    if (!req_ready_o) begin
      timeout_fail({name, " accept"});
      idle_req();
      void'(exp_q.pop_front());
      return;
    end
    step();
    idle_req();
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      step();
      lat++;
    end
    if (!rsp_valid_o) begin
      timeout_fail({name, " rsp"});
      void'(exp_q.pop_front());
      return;
    end
    check({name, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'(WS + 1));
    e = exp_q.pop_front();
    check({name, " rdata"}, rsp_rdata_o, e[31:0]);
    check({name, " err"}, {31'h0, rsp_err_o}, {31'h0, e[32]});
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string n, input logic we, input logic [31:0] a,
                                  input logic [3:0] be, input logic [31:0] wd,
                                  input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = n; v.we = we; v.addr = a; v.be = be; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  logic [31:0] model_mem [8];

  initial begin
    logic [32:0] e;
    int guard;

    add_vec("st_full",      1, 32'h2000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0,         0);
    add_vec("ld_full",      0, 32'h2000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 0);
    add_vec("st_base20",    1, 32'h2000_0020, 4'hF, 32'h1122_3344, 32'h0,         0);
    add_vec("st_lane2",     1, 32'h2000_0020, 4'h4, 32'h00AA_0000, 32'h0,         0);
    add_vec("ld_merged",    0, 32'h2000_0020, 4'hF, 32'h0,         32'h11AA_3344, 0);
    add_vec("ld_lanes01",   0, 32'h2000_0020, 4'h3, 32'h0,         32'h0000_3344, 0);
    add_vec("ld_wrong_dev", 0, 32'h4000_0000, 4'hF, 32'h0,         32'h0,         1);
    add_vec("ld_past_end",  0, 32'h2000_1000, 4'hF, 32'h0,         32'h0,         1);
    add_vec("ld_far_win",   0, 32'h2FFF_FFFC, 4'hF, 32'h0,         32'h0,         1);
    add_vec("st_word0",     1, 32'h2000_0000, 4'hF, 32'hCAFE_F00D, 32'h0,         0);
    add_vec("st_misalign",  1, 32'h2000_0002, 4'hF, 32'h1234_5678, 32'h0,         1);
    add_vec("ld_word0_a",   0, 32'h2000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 0);
    add_vec("st_be_zero",   1, 32'h2000_0000, 4'h0, 32'hFFFF_FFFF, 32'h0,         1);
    add_vec("ld_word0_b",   0, 32'h2000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 0);
    add_vec("ld_be_zero",   0, 32'h2000_0000, 4'h0, 32'h0,         32'h0,         1);
    add_vec("st_last",      1, 32'h2000_0FFC, 4'hF, 32'hA5A5_5A5A, 32'h0,         0);
    add_vec("ld_last",      0, 32'h2000_0FFC, 4'hF, 32'h0,         32'hA5A5_5A5A, 0);
    add_vec("ld_low_dev",   0, 32'h1000_0000, 4'hF, 32'h0,         32'h0,         1);
    add_vec("st_55",        1, 32'h2000_0004, 4'hF, 32'h0000_0055, 32'h0,         0);
    add_vec("ld_55_b9",     0, 32'h2000_0004, 4'h9, 32'h0,         32'h0000_0055, 0);

    // ---- reset ----
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    idle_req();
    step();
    step();
    check("rst req_ready", {31'h0, req_ready_o}, 32'h0);
    check("rst rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst rsp_err",   {31'h0, rsp_err_o}, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst req_ready", {31'h0, req_ready_o}, 32'h1);

    // ---- table ----
    foreach (vecs[i]) begin
      do_txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].be,
             vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // ---- backpressure: response held 5 cycles, queued request waits ----
    rsp_ready_i = 1'b0;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    drive_req(1'b0, 32'h2000_0010, 4'hF, 32'h0);
    check("bp accept_ready", {31'h0, req_ready_o}, 32'h1);
    step();
    idle_req();
    guard = 0;
    while (!rsp_valid_o && guard < 20) begin
      step();
      guard++;
    end
    if (!rsp_valid_o) timeout_fail("bp rsp");
    e = exp_q.pop_front();
    drive_req(1'b0, 32'h2000_0020, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check("bp hold valid", {31'h0, rsp_valid_o}, 32'h1);
      check("bp hold rdata", rsp_rdata_o, e[31:0]);
      check("bp hold err",   {31'h0, rsp_err_o}, {31'h0, e[32]});
      check("bp hold ready", {31'h0, req_ready_o}, 32'h0);
      step();
    end
    rsp_ready_i = 1'b1;
    step();
    check("bp after_hs valid", {31'h0, rsp_valid_o}, 32'h0);
    check("bp after_hs ready", {31'h0, req_ready_o}, 32'h1);
    exp_q.push_back({1'b0, 32'h11AA_3344});
    step();
    idle_req();
    check("bp queued in_wait valid", {31'h0, rsp_valid_o}, 32'h0);
    check("bp queued in_wait ready", {31'h0, req_ready_o}, 32'h0);
    step();
    e = exp_q.pop_front();
    check("bp queued valid", {31'h0, rsp_valid_o}, 32'h1);
    check("bp queued rdata", rsp_rdata_o, e[31:0]);
    step();

    // ---- reset during WAIT of a load ----
    drive_req(1'b0, 32'h2000_0010, 4'hF, 32'h0);
    step();
    idle_req();
    rst = 1'b1;
    step();
    check("midrst valid", {31'h0, rsp_valid_o}, 32'h0);
    check("midrst ready", {31'h0, req_ready_o}, 32'h0);
    rst = 1'b0;
    step();
    check("midrst released ready", {31'h0, req_ready_o}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      check("midrst no_stale", {31'h0, rsp_valid_o}, 32'h0);
      step();
    end

    // ---- counted sequence (stats: 3 loads, 2 stores, 1 error) ----
    do_txn("keep_55",  0, 32'h2000_0004, 4'hF, 32'h0,         32'h0000_0055, 0);
    do_txn("cnt_ld2",  0, 32'h2000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 0);
    do_txn("cnt_ld3",  0, 32'h2000_0FFC, 4'hF, 32'h0,         32'hA5A5_5A5A, 0);
    do_txn("cnt_st1",  1, 32'h2000_0004, 4'hF, 32'h0000_0055, 32'h0,         0);
    do_txn("cnt_st2",  1, 32'h2000_0008, 4'h3, 32'h0000_BEEF, 32'h0,         0);
    do_txn("cnt_err1", 0, 32'h5000_0000, 4'hF, 32'h0,         32'h0,         1);
`ifdef DMEM_ACCESS_STATS_EN
    check("stat_rd",  {16'h0, stat_rd_o},  32'd3);
    check("stat_wr",  {16'h0, stat_wr_o},  32'd2);
    check("stat_err", {16'h0, stat_err_o}, 32'd1);
    force dut.stat_rd_q = 16'hFFFF;
    step();
    release dut.stat_rd_q;
    do_txn("sat_ld", 0, 32'h2000_0004, 4'hF, 32'h0, 32'h0000_0055, 0);
    check("stat_rd sat", {16'h0, stat_rd_o}, 32'h0000_FFFF);
`endif

    // ---- randomized loads/stores against a word model ----
    for (int w = 0; w < 8; w++) begin
      model_mem[w] = $urandom();
      do_txn("rnd_init", 1, 32'h2000_0100 + 32'(w * 4), 4'hF, model_mem[w], 32'h0, 0);
    end
    for (int n = 0; n < 30; n++) begin
      int          idx;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wd;
      idx = $urandom_range(0, 7);
      we  = 1'($urandom_range(0, 1));
      be  = 4'($urandom_range(1, 15));
      wd  = $urandom();
      if (we) begin
        do_txn("rnd_st", 1, 32'h2000_0100 + 32'(idx * 4), be, wd, 32'h0, 0);
        model_mem[idx] = (model_mem[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
      end else begin
        do_txn("rnd_ld", 0, 32'h2000_0100 + 32'(idx * 4), be, 32'h0,
               model_mem[idx] & lane_mask(be), 0);
      end
    end

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
